axi_ar_error_responder: RTL and testbench

Completes read requests that the AR address decoder could not route to any initiator port (no region match, or match masked by the connectivity map). It captures the request's ID, LEN and USER on the decoder's sample strobe and waits for all routed reads of that target to drain. It then grants the decoder and returns an AXI4 read burst of ARLEN+1 beats with RRESP=DECERR toward the target-side R response path. The block sits alongside the AR decoder in each target port of the interconnect; a one-deep pending slot absorbs a second error request that arrives while a burst is still being returned.

---
 rtl/axi_ar_error_responder.sv | 148 ++++++++++++++
 tb/tb_axi_ar_error_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_error_responder.sv
// ----------------------------------------------------------------------------
// axi_ar_error_responder
//
// This block completes AXI4 read requests that the AR decoder could not route.
// The cause is either no region match or a match that the connectivity map
// masked out. The request's ID, LEN and USER are captured on the decoder's
// sample strobe. The block then waits until every routed read of this target
// has drained. After that it grants the decoder and returns ARLEN+1 R beats
// with RRESP=DECERR. A one-deep pending slot holds a second error request
// that arrives while a burst is still being returned.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   sample_ardata_info_i    one-cycle strobe: unroutable AR accepted
//   arid_i/arlen_i/aruser_i request fields, valid with the strobe
//   outstanding_trans_i     routed reads of this target still in flight
//   error_gnt_o             grant that releases the decoder from its stall
//   rvalid_o/rready_i       R handshake
//   rdata_o                 always zero
//   rresp_o                 always DECERR (2'b11)
//   rlast_o                 last beat of the burst
//   rid_o/ruser_o           captured ARID/ARUSER
// ----------------------------------------------------------------------------
module axi_ar_error_responder #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 6,
  parameter int AXI_USER_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_ardata_info_i,
  input  logic [AXI_ID_W-1:0]   arid_i,
  input  logic [7:0]            arlen_i,
  input  logic [AXI_USER_W-1:0] aruser_i,
  input  logic                  outstanding_trans_i,
  output logic                  error_gnt_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [AXI_DATA_W-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic [AXI_ID_W-1:0]   rid_o,
  output logic [AXI_USER_W-1:0] ruser_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                r_state;
  logic [AXI_ID_W-1:0]   r_id;
  logic [7:0]            r_len;
  logic [AXI_USER_W-1:0] r_user;
  logic                  r_pend_vld;
  logic [AXI_ID_W-1:0]   r_pend_id;
  logic [7:0]            r_pend_len;
  logic [AXI_USER_W-1:0] r_pend_user;
  logic [7:0]            r_cnt;

  logic w_gnt;
  logic w_hs;
  logic w_last;
  logic w_pend_cap;

  assign w_gnt      = (r_state == WAIT) && !outstanding_trans_i;
  assign w_hs       = (r_state == SEND) && rready_i;
  // The last beat is detected at counter == len, so ARLEN=255 ends at 255
  // and the 8-bit counter never wraps.
  assign w_last     = (r_cnt == r_len);
  // While pending is already full, a strobe is a protocol violation and is
  // dropped.
  assign w_pend_cap = sample_ardata_info_i && !r_pend_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_len       <= '0;
      r_user      <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_id   <= '0;
      r_pend_len  <= '0;
      r_pend_user <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_ardata_info_i) begin
            r_id    <= arid_i;
            r_len   <= arlen_i;
            r_user  <= aruser_i;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // A strobe seen here is a protocol violation and is ignored.
          if (w_gnt) begin
            r_cnt   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_hs && w_last) begin
            if (w_pend_cap) begin
              // The strobe coincides with the final handshake. It would be
              // captured as pending and then copied straight to active, so
              // it is forwarded to active directly.
              r_id    <= arid_i;
              r_len   <= arlen_i;
              r_user  <= aruser_i;
              r_state <= WAIT;
            end else if (r_pend_vld) begin
              r_id       <= r_pend_id;
              r_len      <= r_pend_len;
              r_user     <= r_pend_user;
              r_pend_vld <= 1'b0;
              r_state    <= WAIT;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            if (w_hs) begin
              r_cnt <= r_cnt + 8'd1;
            end
            if (w_pend_cap) begin
              r_pend_vld  <= 1'b1;
              r_pend_id   <= arid_i;
              r_pend_len  <= arlen_i;
              r_pend_user <= aruser_i;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign error_gnt_o = w_gnt;
  assign rvalid_o    = (r_state == SEND);
  assign rlast_o     = (r_state == SEND) && w_last;
  assign rid_o       = r_id;
  assign ruser_o     = r_user;
  assign rdata_o     = '0;
  assign rresp_o     = 2'b11;

endmodule

// File: tb/tb_axi_ar_error_responder.sv
// ----------------------------------------------------------------------------
// tb_axi_ar_error_responder
//
// Directed testbench for axi_ar_error_responder. Inputs are driven 1 ns after
// each rising edge. Outputs are observed 1-2 ns later, well away from the
// next edge.
// ----------------------------------------------------------------------------
module tb_axi_ar_error_responder;

  logic        clk;
  logic        rst_n;
  logic        sample_ardata_info_i;
  logic [5:0]  arid_i;
  logic [7:0]  arlen_i;
  logic [5:0]  aruser_i;
  logic        outstanding_trans_i;
  logic        error_gnt_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic [5:0]  rid_o;
  logic [5:0]  ruser_o;

  int checks   = 0;
  int failures = 0;

  axi_ar_error_responder #(
    .AXI_DATA_W(64),
    .AXI_ID_W  (6),
    .AXI_USER_W(6)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sample_ardata_info_i(sample_ardata_info_i),
    .arid_i              (arid_i),
    .arlen_i             (arlen_i),
    .aruser_i            (aruser_i),
    .outstanding_trans_i (outstanding_trans_i),
    .error_gnt_o         (error_gnt_o),
    .rvalid_o            (rvalid_o),
    .rready_i            (rready_i),
    .rdata_o             (rdata_o),
    .rresp_o             (rresp_o),
    .rlast_o             (rlast_o),
    .rid_o               (rid_o),
    .ruser_o             (ruser_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one strobe while the DUT is in IDLE. Returns one cycle later,
  // with the DUT in WAIT.
  task automatic send_req(input logic [5:0] id, input logic [7:0] len, input logic [5:0] user);
    sample_ardata_info_i = 1'b1;
    arid_i   = id;
    arlen_i  = len;
    aruser_i = user;
    #1;
    chk("idle_gnt", error_gnt_o, 0);
    chk("idle_rvalid", rvalid_o, 0);
    tick();
    sample_ardata_info_i = 1'b0;
  endtask

  // Collect one burst. A strobe can be injected during handshake number
  // inj_at (1-based); 0 means no injection.
  task automatic collect(input string tag, input int exp_beats, input logic [5:0] eid,
                         input logic [5:0] euser, input bit rnd, input int inj_at,
                         input logic [5:0] iid, input logic [7:0] ilen,
                         input logic [5:0] iuser, input int max_cyc);
    int   beats   = 0;
    bit   done    = 0;
    bit   stalled = 0;
    logic [5:0] sid;
    logic [5:0] suser;
    logic       slast;
    sid = '0; suser = '0; slast = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      rready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      sample_ardata_info_i = 1'b0;
      if (rvalid_o && rready_i && (beats + 1 == inj_at)) begin
        sample_ardata_info_i = 1'b1;
        arid_i   = iid;
        arlen_i  = ilen;
        aruser_i = iuser;
      end
      #1;
      if (stalled) begin
        chk({tag, "_stall_rvalid"}, rvalid_o, 1);
        chk({tag, "_stall_rid"}, rid_o, sid);
        chk({tag, "_stall_ruser"}, ruser_o, suser);
        chk({tag, "_stall_rlast"}, rlast_o, slast);
      end
      if (rvalid_o) begin
        if (rready_i) begin
          beats++;
          chk({tag, "_rlast"}, rlast_o, (beats == exp_beats));
          chk({tag, "_rid"}, rid_o, eid);
          chk({tag, "_ruser"}, ruser_o, euser);
          chk({tag, "_gnt_in_send"}, error_gnt_o, 0);
          if (beats == 1) begin
            chk({tag, "_rresp"}, rresp_o, 2'b11);
            chk({tag, "_rdata"}, rdata_o, 64'd0);
          end
          if (rlast_o) done = 1;
          stalled = 0;
        end else begin
          stalled = 1;
          sid   = rid_o;
          suser = ruser_o;
          slast = rlast_o;
        end
      end
      tick();
    end
    sample_ardata_info_i = 1'b0;
    rready_i = 1'b1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_beats"}, beats, exp_beats);
  endtask

  initial begin
    rst_n                = 1'b0;
    sample_ardata_info_i = 1'b0;
    arid_i               = '0;
    arlen_i              = '0;
    aruser_i             = '0;
    outstanding_trans_i  = 1'b0;
    rready_i             = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rlast", rlast_o, 0);
    chk("rst_gnt", error_gnt_o, 0);
    chk("rst_rid", rid_o, 0);
    chk("rst_ruser", ruser_o, 0);
    chk("rst_rresp", rresp_o, 2'b11);
    chk("rst_rdata", rdata_o, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single beat
    send_req(6'h05, 8'd0, 6'h2A);
    #1;
    chk("single_gnt", error_gnt_o, 1);
    chk("single_wait_rvalid", rvalid_o, 0);
    tick();
    collect("single", 1, 6'h05, 6'h2A, 0, 0, 6'h00, 8'd0, 6'h00, 4);
    #1;
    chk("single_idle_rvalid", rvalid_o, 0);
    chk("single_idle_gnt", error_gnt_o, 0);
    tick();

    // Drain wait, plus a stray strobe in WAIT that must be ignored
    outstanding_trans_i = 1'b1;
    send_req(6'h07, 8'd3, 6'h01);
    for (int i = 0; i < 10; i++) begin
      sample_ardata_info_i = 1'b0;
      if (i == 3) begin
        sample_ardata_info_i = 1'b1;
        arid_i   = 6'h3F;
        arlen_i  = 8'd9;
        aruser_i = 6'h3F;
      end
      #1;
      chk("drain_gnt_low", error_gnt_o, 0);
      chk("drain_rvalid_low", rvalid_o, 0);
      tick();
    end
    sample_ardata_info_i = 1'b0;
    outstanding_trans_i  = 1'b0;
    #1;
    chk("drain_gnt", error_gnt_o, 1);
    tick();
    collect("drain", 4, 6'h07, 6'h01, 0, 0, 6'h00, 8'd0, 6'h00, 10);

    // Backpressure
    send_req(6'h2A, 8'd7, 6'h2B);
    #1;
    chk("bp_gnt", error_gnt_o, 1);
    tick();
    collect("bp", 8, 6'h2A, 6'h2B, 1, 0, 6'h00, 8'd0, 6'h00, 300);

    // Pending strobe during the first beat
    send_req(6'h21, 8'd3, 6'h03);
    #1;
    chk("pend_gnt1", error_gnt_o, 1);
    tick();
    collect("pend_a", 4, 6'h21, 6'h03, 0, 1, 6'h11, 8'd1, 6'h15, 10);
    #1;
    chk("pend_gnt2", error_gnt_o, 1);
    chk("pend_wait_rvalid", rvalid_o, 0);
    tick();
    collect("pend_b", 2, 6'h11, 6'h15, 0, 0, 6'h00, 8'd0, 6'h00, 10);
    #1;
    chk("pend_idle_gnt", error_gnt_o, 0);
    tick();

    // Pending strobe coincident with the last handshake
    send_req(6'h22, 8'd3, 6'h04);
    #1;
    chk("coin_gnt1", error_gnt_o, 1);
    tick();
    collect("coin_a", 4, 6'h22, 6'h04, 0, 4, 6'h12, 8'd1, 6'h16, 10);
    #1;
    chk("coin_gnt2", error_gnt_o, 1);
    tick();
    collect("coin_b", 2, 6'h12, 6'h16, 0, 0, 6'h00, 8'd0, 6'h00, 10);

    // Maximum length
    send_req(6'h3C, 8'd255, 6'h0D);
    #1;
    chk("max_gnt", error_gnt_o, 1);
    tick();
    collect("max", 256, 6'h3C, 6'h0D, 0, 0, 6'h00, 8'd0, 6'h00, 300);
    #1;
    chk("max_idle_rvalid", rvalid_o, 0);
    tick();

    // Reset mid-burst
    send_req(6'h09, 8'd5, 6'h06);
    #1;
    chk("rstm_gnt", error_gnt_o, 1);
    tick();
    rready_i = 1'b1;
    tick();
    chk("rstm_beat2_rvalid", rvalid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_rvalid", rvalid_o, 0);
    chk("rstm_rlast", rlast_o, 0);
    chk("rstm_gnt0", error_gnt_o, 0);
    chk("rstm_rid", rid_o, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstm_idle_rvalid", rvalid_o, 0);
    chk("rstm_idle_gnt", error_gnt_o, 0);
    tick();
    send_req(6'h0A, 8'd0, 6'h0B);
    #1;
    chk("rstm_new_gnt", error_gnt_o, 1);
    tick();
    collect("rstm_new", 1, 6'h0A, 6'h0B, 0, 0, 6'h00, 8'd0, 6'h00, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
